// File: rtl/scalar_pkg.sv
// scalar_pkg: shared widths and the writeback entry type for the scalar datapath.
package scalar_pkg;
    localparam int REG_ADDR_W = 3;
    localparam int DATA_W = 16;
    localparam int NUM_REGS = 8;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
    typedef enum logic {SRC_ALU, SRC_LD} wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback entries; exposes per-slot contents so
// the owner can scan pending destinations.
module wb_fifo
    import scalar_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  wb_entry_t din,
    input  logic pop,
    output wb_entry_t dout,
    output logic full,
    output logic empty,
    output logic [CW-1:0] count,
    output wb_entry_t [DEPTH-1:0] entries,
    output logic [DEPTH-1:0] slot_valid
);
    wb_entry_t [DEPTH-1:0] mem;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    assign entries = mem;
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            slot_valid <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
            if (do_pop) slot_valid[rd_ptr] <= 1'b0;
            if (do_push) slot_valid[wr_ptr] <= 1'b1;
        end
    end
endmodule

// File: rtl/scalar_writeback.sv
// scalar_writeback: merges ALU and load results into one registered register-file
// write per cycle and reports which registers have writes in flight.
module scalar_writeback
    import scalar_pkg::*;
#(
    parameter int LD_DEPTH = 4,
    localparam int CW = $clog2(LD_DEPTH) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_dst,
    input  logic [DATA_W-1:0] alu_data,
    output logic alu_ready,
    input  logic ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_dst,
    input  logic [DATA_W-1:0] ld_data,
    output logic ld_ready,
    output logic wr_en,
    output logic [REG_ADDR_W-1:0] wr_dst,
    output logic [DATA_W-1:0] wr_data,
    output logic [NUM_REGS-1:0] busy,
    output logic [CW-1:0] ld_count
);
    logic hold_v, ld_full, ld_empty, grant_ld, grant_alu;
    wb_entry_t hold, ld_head;
    wb_entry_t [LD_DEPTH-1:0] ld_entries;
    logic [LD_DEPTH-1:0] ld_slot_valid;
    logic [CW-1:0] count;
    logic [NUM_REGS-1:0] pending;
    wb_src_e rr_last;
    wb_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(ld_valid && ld_ready),
        .din({ld_dst, ld_data}),
        .pop(grant_ld),
        .dout(ld_head),
        .full(ld_full),
        .empty(ld_empty),
        .count(count),
        .entries(ld_entries),
        .slot_valid(ld_slot_valid)
    );
    // A full FIFO wins outright so loads cannot be starved into backpressure.
    assign grant_ld = !ld_empty && (!hold_v || ld_full || rr_last == SRC_ALU);
    assign grant_alu = hold_v && !grant_ld;
    assign alu_ready = !rst && (!hold_v || grant_alu);
    assign ld_ready = !rst && !ld_full;
    assign ld_count = rst ? '0 : count;
    assign busy = rst ? '0 : pending;
    always_ff @(posedge clk) begin
        if (rst) hold_v <= 1'b0;
        else if (alu_valid && alu_ready) begin
            hold_v <= 1'b1;
            hold <= {alu_dst, alu_data};
        end else if (grant_alu) hold_v <= 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) rr_last <= SRC_ALU;
        else if (hold_v && !ld_empty && !ld_full) rr_last <= grant_ld ? SRC_LD : SRC_ALU;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en <= 1'b0;
            wr_dst <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= grant_ld || grant_alu;
            if (grant_ld) {wr_dst, wr_data} <= ld_head;
            else if (grant_alu) {wr_dst, wr_data} <= hold;
        end
    end
    always_comb begin
        pending = '0;
        if (hold_v) pending[hold.dst] = 1'b1;
        for (int i = 0; i < LD_DEPTH; i++)
            if (ld_slot_valid[i]) pending[ld_entries[i].dst] = 1'b1;
        if (wr_en) pending[wr_dst] = 1'b1;
    end
endmodule
